// File: rtl/bmp_reader.sv
// BMP file streamer: reads the 54-byte header from an image ROM, validates the
// signature and pixel-data offset, then streams every byte from the offset to
// the end of the file through a 2-entry ready/valid output buffer.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for start
// HDR    | requesting header bytes 0..53 and capturing the returns
// CHECK  | one cycle to validate signature and offset
// PIXEL  | requesting pixel bytes from offset up to the last file byte
// DRAIN  | all requests issued, emptying the output buffer
// DONE   | file fully delivered, waiting for the next start
// ERROR  | header rejected, waiting for the next start
module bmp_reader #(
   parameter int ADDR_WIDTH     = 20,
   parameter int BYTE_WIDTH     = 8,
   parameter int BMP_TOTAL_SIZE = 786486
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  rom_valid,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [BYTE_WIDTH-1:0] rom_q,
   output logic                  pix_valid,
   output logic [7:0]            pix_data,
   output logic                  pix_last,
   input  logic                  pix_ready,
   output logic [31:0]           img_width,
   output logic [31:0]           img_height,
   output logic [15:0]           img_bpp,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int                    HDR_BYTES = 54;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BMP_TOTAL_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] HDR_LAST  = ADDR_WIDTH'(HDR_BYTES - 1);
   localparam logic [31:0]           TOTAL_32  = 32'(BMP_TOTAL_SIZE);
   localparam logic [31:0]           HDR_32    = 32'(HDR_BYTES);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_CHECK, S_PIXEL, S_DRAIN, S_DONE, S_ERROR
   } state_t;

   state_t                 state;
   logic [5:0]             hdr_cnt;
   logic [ADDR_WIDTH-1:0]  pix_ptr;
   logic [7:0]             sig0;
   logic [7:0]             sig1;
   logic [31:0]            offset;

   logic                   ret_valid;
   logic                   ret_last;
   logic [ADDR_WIDTH-1:0]  ret_addr;

   logic [7:0]             fifo_data [2];
   logic                   fifo_last [2];
   logic                   wr_ptr;
   logic                   rd_ptr;
   logic [1:0]             fifo_cnt;

   logic                   start_ok;
   logic                   push;
   logic                   pop;
   logic [7:0]             byte_in;

   assign byte_in   = rom_q[7:0];
   assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
   assign pix_valid = (fifo_cnt != 2'd0);
   assign pix_data  = pix_valid ? fifo_data[rd_ptr] : 8'h00;
   assign pix_last  = pix_valid && fifo_last[rd_ptr];
   assign pop       = pix_valid && pix_ready;
   assign push      = ret_valid && (state == S_PIXEL || state == S_DRAIN);

   // ROM request: combinational so a same-cycle pop can free a slot, which is
   // what lets a 2-entry buffer sustain one byte per cycle.
   always_comb begin
      rom_valid = 1'b0;
      rom_addr  = '0;
      case (state)
         S_HDR: begin
            if (hdr_cnt < 6'(HDR_BYTES)) begin
               rom_valid = 1'b1;
               rom_addr  = ADDR_WIDTH'(hdr_cnt);
            end
         end
         S_PIXEL: begin
            if ((3'(fifo_cnt) + 3'(ret_valid)) < (3'd2 + 3'(pop))) begin
               rom_valid = 1'b1;
               rom_addr  = pix_ptr;
            end
         end
         default: ;
      endcase
   end

   // Track the single request whose data comes back on rom_q next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ret_valid <= 1'b0;
         ret_addr  <= '0;
         ret_last  <= 1'b0;
      end else begin
         ret_valid <= rom_valid;
         ret_addr  <= rom_addr;
         ret_last  <= rom_valid && (state == S_PIXEL) && (rom_addr == LAST_ADDR);
      end
   end

   // Sequencer: header walk, header capture, validation and pixel pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         hdr_cnt    <= '0;
         pix_ptr    <= '0;
         sig0       <= '0;
         sig1       <= '0;
         offset     <= '0;
         img_width  <= '0;
         img_height <= '0;
         img_bpp    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_ok) begin
                  state      <= S_HDR;
                  hdr_cnt    <= '0;
                  sig0       <= '0;
                  sig1       <= '0;
                  offset     <= '0;
                  img_width  <= '0;
                  img_height <= '0;
                  img_bpp    <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            S_HDR: begin
               if (rom_valid) hdr_cnt <= hdr_cnt + 6'd1;
               if (ret_valid) begin
                  case (ret_addr[5:0])
                     6'd0:  sig0              <= byte_in;
                     6'd1:  sig1              <= byte_in;
                     6'd10: offset[7:0]       <= byte_in;
                     6'd11: offset[15:8]      <= byte_in;
                     6'd12: offset[23:16]     <= byte_in;
                     6'd13: offset[31:24]     <= byte_in;
                     6'd18: img_width[7:0]    <= byte_in;
                     6'd19: img_width[15:8]   <= byte_in;
                     6'd20: img_width[23:16]  <= byte_in;
                     6'd21: img_width[31:24]  <= byte_in;
                     6'd22: img_height[7:0]   <= byte_in;
                     6'd23: img_height[15:8]  <= byte_in;
                     6'd24: img_height[23:16] <= byte_in;
                     6'd25: img_height[31:24] <= byte_in;
                     6'd28: img_bpp[7:0]      <= byte_in;
                     6'd29: img_bpp[15:8]     <= byte_in;
                     default: ;
                  endcase
                  if (ret_addr == HDR_LAST) state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (sig0 != 8'h42 || sig1 != 8'h4D || offset < HDR_32 || offset >= TOTAL_32) begin
                  state <= S_ERROR;
                  busy  <= 1'b0;
                  error <= 1'b1;
               end else begin
                  state   <= S_PIXEL;
                  pix_ptr <= ADDR_WIDTH'(offset);
               end
            end
            S_PIXEL: begin
               if (rom_valid) begin
                  pix_ptr <= pix_ptr + 1'b1;
                  if (pix_ptr == LAST_ADDR) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && pix_last) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Output buffer: push on ROM return, pop on accepted transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_cnt     <= '0;
      end else if (start_ok) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_last[0] <= 1'b0;
         fifo_last[1] <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_cnt     <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= byte_in;
            fifo_last[wr_ptr] <= ret_last;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bmp_reader.sv
// Self-checking bench for bmp_reader: ROM model, transfer monitor and a
// reference model that derives the expected byte stream and request list
// directly from the file contents.
module tb_bmp_reader;

   localparam int AW    = 20;
   localparam int TOTAL = 78;
   localparam int HDR   = 54;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          pix_ready = 1'b0;
   logic          rom_valid;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_q = 8'h00;
   logic          pix_valid;
   logic [7:0]    pix_data;
   logic          pix_last;
   logic [31:0]   img_width;
   logic [31:0]   img_height;
   logic [15:0]   img_bpp;
   logic          busy;
   logic          done;
   logic          error;

   int total = 0;
   int bad   = 0;

   logic [7:0] rom_mem [TOTAL];
   int  exp_off, exp_w, exp_h, exp_bpp;
   bit  exp_ok;

   int         cyc = 0;
   bit         mon_en = 1'b0;
   logic [7:0] got_data [$];
   bit         got_last [$];
   int         got_cyc  [$];
   int         req_addr [$];
   int         req_cyc  [$];
   int         pv_count, first_pv, done_cyc;
   int         viol_stable, viol_occ, viol_addr0;
   bit         prev_stall;
   logic [7:0] prev_data;
   logic       prev_last;
   bit         timed_out;
   logic [7:0] saved [$];

   bmp_reader #(.ADDR_WIDTH(AW), .BYTE_WIDTH(8), .BMP_TOTAL_SIZE(TOTAL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .rom_valid(rom_valid), .rom_addr(rom_addr), .rom_q(rom_q),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last), .pix_ready(pix_ready),
      .img_width(img_width), .img_height(img_height), .img_bpp(img_bpp),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // ROM: data one cycle after the sampled request, junk otherwise.
   always @(posedge clk)
      rom_q <= (rom_valid && rom_addr < AW'(TOTAL)) ? rom_mem[int'(rom_addr)] : 8'($urandom);

   // Monitor, mid-cycle: transfers, requests, stall stability, occupancy.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (mon_en && rst_n) begin
            if (!rom_valid && rom_addr != '0) viol_addr0++;
            if (rom_valid) begin
               if (req_addr.size() >= HDR) begin
                  int pend;
                  pend = req_addr.size() - HDR - got_data.size();
                  if (pend - ((pix_valid && pix_ready) ? 1 : 0) >= 2) viol_occ++;
               end
               req_addr.push_back(int'(rom_addr));
               req_cyc.push_back(cyc);
            end
            if (prev_stall && (pix_valid !== 1'b1 || pix_data !== prev_data || pix_last !== prev_last))
               viol_stable++;
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
            if (pix_valid) begin
               pv_count++;
               if (first_pv < 0) first_pv = cyc;
            end
            if (pix_valid && pix_ready) begin
               got_data.push_back(pix_data);
               got_last.push_back(pix_last);
               got_cyc.push_back(cyc);
            end
            if (done && done_cyc < 0 && got_data.size() > 0) done_cyc = cyc;
         end else begin
            prev_stall = 1'b0;
         end
      end
   end

   task automatic clear_mon();
      got_data.delete(); got_last.delete(); got_cyc.delete();
      req_addr.delete(); req_cyc.delete();
      pv_count = 0; first_pv = -1; done_cyc = -1;
      viol_stable = 0; viol_occ = 0; viol_addr0 = 0;
      prev_stall = 1'b0;
   endtask

   task automatic build_rom(input int w, input int h, input int bpp, input int off,
                            input logic [7:0] s0, input logic [7:0] s1);
      for (int i = 0; i < TOTAL; i++) rom_mem[i] = 8'($urandom);
      rom_mem[0] = s0;
      rom_mem[1] = s1;
      for (int b = 0; b < 4; b++) begin
         rom_mem[10+b] = 8'(off >> (8*b));
         rom_mem[18+b] = 8'(w >> (8*b));
         rom_mem[22+b] = 8'(h >> (8*b));
      end
      rom_mem[28] = 8'(bpp);
      rom_mem[29] = 8'(bpp >> 8);
      exp_off = off; exp_w = w; exp_h = h; exp_bpp = bpp;
      exp_ok  = (s0 == 8'h42) && (s1 == 8'h4D) && (off >= HDR) && (off < TOTAL);
   endtask

   function automatic bit ready_for(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k % 6 == 0) || (k % 6 == 3) || (k % 6 == 5);
         default: return $urandom_range(0, 3) != 0;
      endcase
   endfunction

   // Deviations of the received stream from the file bytes offset..end.
   function automatic int stream_errors();
      int n = 0;
      int exp_n = exp_ok ? TOTAL - exp_off : 0;
      if (got_data.size() != exp_n) n++;
      for (int i = 0; i < got_data.size() && i < exp_n; i++) begin
         if (got_data[i] !== rom_mem[exp_off+i]) n++;
         if (got_last[i] != (exp_off + i == TOTAL - 1)) n++;
      end
      return n;
   endfunction

   // Deviations of the ROM request list from 0..53 then offset..end.
   function automatic int req_errors();
      int e [$];
      int n = 0;
      for (int i = 0; i < HDR; i++) e.push_back(i);
      if (exp_ok) for (int a = exp_off; a < TOTAL; a++) e.push_back(a);
      if (req_addr.size() != e.size()) n++;
      for (int i = 0; i < req_addr.size() && i < e.size(); i++)
         if (req_addr[i] != e[i]) n++;
      return n;
   endfunction

   function automatic logic outs_nonzero();
      return |{rom_valid, rom_addr, pix_valid, pix_data, pix_last, busy, done, error,
               img_width, img_height, img_bpp};
   endfunction

   // Entered and left at posedge+1.
   task automatic run_read(input int mode, input int inj_a, input int inj_b);
      bit hit = 1'b0;
      clear_mon();
      mon_en    = 1'b1;
      start     = 1'b1;
      pix_ready = ready_for(mode, 0);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 3000 && !hit; k++) begin
         pix_ready = ready_for(mode, k);
         start     = (k == inj_a) || (k == inj_b);
         @(negedge clk);
         if (done || error) hit = 1'b1;
         @(posedge clk); #1;
      end
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pix_ready = ready_for(mode, k);
         @(posedge clk); #1;
      end
      timed_out = !hit;
   endtask

   task automatic test_reset();
      #12;
      total++; if (rom_valid !== 1'b0) begin bad++; $display("FAIL reset_rom_valid: got %0b want 0", rom_valid); end
      total++; if (rom_addr !== '0) begin bad++; $display("FAIL reset_rom_addr: got %0h want 0", rom_addr); end
      total++; if ({pix_valid, pix_data, pix_last} !== 10'd0) begin bad++; $display("FAIL reset_pix: got %0h want 0", {pix_valid, pix_data, pix_last}); end
      total++; if ({busy, done, error} !== 3'b000) begin bad++; $display("FAIL reset_status: got %03b want 000", {busy, done, error}); end
      total++; if ({img_width, img_height, img_bpp} !== 80'd0) begin bad++; $display("FAIL reset_img: got %0h want 0", {img_width, img_height, img_bpp}); end
      @(posedge clk); #1; rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if ({busy, rom_valid, pix_valid} !== 3'b000) begin bad++; $display("FAIL idle_after_reset: got %03b want 000", {busy, rom_valid, pix_valid}); end
   endtask

   task automatic test_valid_4x2();
      int span, lat, chk;
      build_rom(4, 2, 24, 54, 8'h42, 8'h4D);
      run_read(0, -1, -1);
      span = (got_cyc.size() > 0) ? got_cyc[$] - got_cyc[0] : -1;
      lat  = (req_cyc.size() > HDR && first_pv >= 0) ? first_pv - req_cyc[HDR] : -1;
      chk  = (req_cyc.size() > HDR) ? req_cyc[HDR] - req_cyc[HDR-1] : -1;
      total++; if (timed_out !== 1'b0) begin bad++; $display("FAIL v4x2_timeout: got %0b want 0", timed_out); end
      total++; if (img_width !== 32'd4) begin bad++; $display("FAIL v4x2_width: got %0d want 4", img_width); end
      total++; if (img_height !== 32'd2) begin bad++; $display("FAIL v4x2_height: got %0d want 2", img_height); end
      total++; if (img_bpp !== 16'd24) begin bad++; $display("FAIL v4x2_bpp: got %0d want 24", img_bpp); end
      total++; if (got_data.size() != 24) begin bad++; $display("FAIL v4x2_count: got %0d want 24", got_data.size()); end
      total++; if (stream_errors() != 0) begin bad++; $display("FAIL v4x2_stream: got %0d errors want 0", stream_errors()); end
      total++; if (req_errors() != 0) begin bad++; $display("FAIL v4x2_requests: got %0d errors want 0", req_errors()); end
      total++; if (span != 23) begin bad++; $display("FAIL v4x2_throughput: got span %0d want 23", span); end
      total++; if (lat != 2) begin bad++; $display("FAIL v4x2_latency: got %0d want 2", lat); end
      total++; if (chk != 3) begin bad++; $display("FAIL v4x2_check_gap: got %0d want 3", chk); end
      total++; if (done_cyc != ((got_cyc.size() > 0) ? got_cyc[$] + 1 : -2)) begin bad++; $display("FAIL v4x2_done_time: got %0d want last+1", done_cyc); end
      total++; if ({busy, done, error} !== 3'b010) begin bad++; $display("FAIL v4x2_status: got %03b want 010", {busy, done, error}); end
      total++; if (viol_addr0 != 0) begin bad++; $display("FAIL v4x2_addr_idle: got %0d want 0", viol_addr0); end
   endtask

   task automatic test_bad_sig();
      build_rom(4, 2, 24, 54, 8'h42, 8'h4E);
      run_read(0, -1, -1);
      total++; if ({busy, done, error} !== 3'b001) begin bad++; $display("FAIL badsig_status: got %03b want 001", {busy, done, error}); end
      total++; if (pv_count != 0) begin bad++; $display("FAIL badsig_pix_valid: got %0d cycles want 0", pv_count); end
      total++; if (req_errors() != 0) begin bad++; $display("FAIL badsig_requests: got %0d errors want 0", req_errors()); end
      total++; if (img_width !== 32'd4) begin bad++; $display("FAIL badsig_width_kept: got %0d want 4", img_width); end
      total++; if ({rom_valid, pix_valid} !== 2'b00) begin bad++; $display("FAIL badsig_idle: got %02b want 00", {rom_valid, pix_valid}); end
   endtask

   task automatic test_bad_offset();
      int offs [2];
      offs[0] = 40;
      offs[1] = TOTAL;
      for (int i = 0; i < 2; i++) begin
         build_rom(8, 8, 8, offs[i], 8'h42, 8'h4D);
         run_read(0, -1, -1);
         total++; if ({busy, done, error} !== 3'b001) begin bad++; $display("FAIL badoff_status off=%0d: got %03b want 001", offs[i], {busy, done, error}); end
         total++; if (pv_count != 0) begin bad++; $display("FAIL badoff_pix_valid off=%0d: got %0d want 0", offs[i], pv_count); end
         total++; if (req_errors() != 0) begin bad++; $display("FAIL badoff_requests off=%0d: got %0d errors want 0", offs[i], req_errors()); end
      end
   endtask

   task automatic test_stall_pattern();
      build_rom(int'($urandom), int'($urandom), 32, 54 + $urandom_range(0, 10), 8'h42, 8'h4D);
      run_read(1, -1, -1);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL stall_done: got %0b want 1", done); end
      total++; if (stream_errors() != 0) begin bad++; $display("FAIL stall_stream: got %0d errors want 0", stream_errors()); end
      total++; if (req_errors() != 0) begin bad++; $display("FAIL stall_requests: got %0d errors want 0", req_errors()); end
      total++; if (viol_stable != 0) begin bad++; $display("FAIL stall_hold: got %0d want 0", viol_stable); end
      total++; if (viol_occ != 0) begin bad++; $display("FAIL stall_occupancy: got %0d want 0", viol_occ); end
      total++; if (img_width !== 32'(exp_w)) begin bad++; $display("FAIL stall_width: got %0h want %0h", img_width, exp_w); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         int off = (it == 0) ? TOTAL - 1 : 54 + $urandom_range(0, TOTAL - 55);
         build_rom(int'($urandom), int'($urandom), $urandom_range(0, 65535), off, 8'h42, 8'h4D);
         run_read(2, -1, -1);
         total++; if (done !== 1'b1 || timed_out) begin bad++; $display("FAIL rand_done it=%0d: got %0b want 1", it, done); end
         total++; if (stream_errors() != 0) begin bad++; $display("FAIL rand_stream it=%0d: got %0d errors want 0", it, stream_errors()); end
         total++; if (req_errors() != 0) begin bad++; $display("FAIL rand_requests it=%0d: got %0d errors want 0", it, req_errors()); end
         total++; if (viol_stable + viol_occ + viol_addr0 != 0) begin bad++; $display("FAIL rand_protocol it=%0d: got %0d want 0", it, viol_stable + viol_occ + viol_addr0); end
         total++; if ({img_height, img_bpp} !== {32'(exp_h), 16'(exp_bpp)}) begin bad++; $display("FAIL rand_header it=%0d: got %0h want %0h", it, {img_height, img_bpp}, {32'(exp_h), 16'(exp_bpp)}); end
      end
   endtask

   task automatic test_reset_mid();
      build_rom(4, 2, 24, 54, 8'h42, 8'h4D);
      clear_mon();
      mon_en = 1'b1;
      start  = 1'b1;
      pix_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k < 500 && got_data.size() < 5; k++) begin
         pix_ready = ready_for(1, k);
         @(posedge clk); #1;
      end
      total++; if (got_data.size() < 5) begin bad++; $display("FAIL rstmid_reach_pixel: got %0d want >=5", got_data.size()); end
      rst_n = 1'b0;
      #1;
      total++; if (outs_nonzero() !== 1'b0) begin bad++; $display("FAIL rstmid_outputs_zero: got %0b want 0", outs_nonzero()); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      for (int k = 0; k < 6; k++) begin
         pix_ready = 1'b1;
         @(posedge clk); #1;
      end
      total++; if (pv_count != 0) begin bad++; $display("FAIL rstmid_stale: got %0d valid cycles want 0", pv_count); end
      total++; if (req_addr.size() != 0) begin bad++; $display("FAIL rstmid_requests: got %0d want 0", req_addr.size()); end
      run_read(0, -1, -1);
      total++; if (stream_errors() != 0) begin bad++; $display("FAIL rstmid_restart_stream: got %0d errors want 0", stream_errors()); end
      total++; if (req_errors() != 0) begin bad++; $display("FAIL rstmid_restart_requests: got %0d errors want 0", req_errors()); end
   endtask

   task automatic test_start_ignored();
      int diff = 0;
      build_rom(640, 480, 24, 54, 8'h42, 8'h4D);
      run_read(1, 10, 70);
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_done: got %0b want 1", done); end
      total++; if (req_errors() != 0) begin bad++; $display("FAIL ign_requests: got %0d errors want 0", req_errors()); end
      total++; if (stream_errors() != 0) begin bad++; $display("FAIL ign_stream: got %0d errors want 0", stream_errors()); end
      total++; if ({img_width, img_height} !== {32'd640, 32'd480}) begin bad++; $display("FAIL ign_header: got %0d x %0d want 640 x 480", img_width, img_height); end
      saved = got_data;
      run_read(0, -1, -1);
      if (got_data.size() != saved.size()) diff++;
      for (int i = 0; i < got_data.size() && i < saved.size(); i++)
         if (got_data[i] !== saved[i]) diff++;
      total++; if (diff != 0) begin bad++; $display("FAIL ign_second_read: got %0d differences want 0", diff); end
      total++; if (done !== 1'b1) begin bad++; $display("FAIL ign_second_done: got %0b want 1", done); end
   endtask

   initial begin
      test_reset();
      test_valid_4x2();
      test_bad_sig();
      test_bad_offset();
      test_stall_pattern();
      test_random();
      test_reset_mid();
      test_start_ignored();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
